// File: rtl/sat_sub_serial.sv
// Bit-serial saturating subtractor: computes max(a - b, 0) one bit per clock,
// LSB first, with an underflow flag. Valid/ready on both operand and result sides.
module sat_sub_serial #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             underflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic             r_underflow;

    logic             w_d;
    logic             w_borrow_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_work_next;
    logic             w_last;

    // One full-subtractor slice on bit 0 of the shifting operands.
    assign w_d           = r_sa[0] ^ r_sb[0] ^ r_borrow;
    assign w_borrow_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
    assign w_count_next  = r_count + CW'(1);
    assign w_work_next   = WIDTH'({w_d, r_work} >> 1);
    assign w_last        = (w_count_next == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this combinational (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = SHIFT;
            SHIFT:   if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa        <= '0;
            r_sb        <= '0;
            r_work      <= '0;
            r_count     <= '0;
            r_borrow    <= 1'b0;
            r_diff      <= '0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_work   <= '0;
                        r_count  <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_work   <= w_work_next;
                    r_count  <= w_count_next;
                    r_borrow <= w_borrow_next;
                    // A final borrow means a < b: clamp to zero.
                    if (w_last) begin
                        r_diff      <= w_borrow_next ? '0 : w_work_next;
                        r_underflow <= w_borrow_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff      = r_diff;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_sat_sub_serial.sv
// Directed bench for sat_sub_serial at WIDTH=2 and WIDTH=8: latency, saturation,
// backpressure hold, ignored operands while busy, and reset abort.
module tb_sat_sub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv2, ir2, ov2, or2, uf2;
    logic [1:0] a2, b2, d2;
    logic       iv8, ir8, ov8, or8, uf8;
    logic [7:0] a8, b8, d8;

    int  n_checks = 0;
    int  n_fail   = 0;
    time t_acc;
    time t_prev;

    sat_sub_serial #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .diff(d2), .underflow(uf2)
    );

    sat_sub_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .underflow(uf8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_ov(input bit w8);
        return w8 ? {31'b0, ov8} : {31'b0, ov2};
    endfunction
    function automatic logic [31:0] get_ir(input bit w8);
        return w8 ? {31'b0, ir8} : {31'b0, ir2};
    endfunction
    function automatic logic [31:0] get_d(input bit w8);
        return w8 ? {24'b0, d8} : {30'b0, d2};
    endfunction
    function automatic logic [31:0] get_uf(input bit w8);
        return w8 ? {31'b0, uf8} : {31'b0, uf2};
    endfunction

    task automatic drive(input bit w8, input logic v, input int a, input int b);
        if (w8) begin
            iv8 = v; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            iv2 = v; a2 = a[1:0]; b2 = b[1:0];
        end
    endtask

    task automatic set_or(input bit w8, input logic r);
        if (w8) or8 = r;
        else    or2 = r;
    endtask

    // Starts at a falling edge with the DUT idle; ends at the falling edge where
    // in_ready has returned, so back-to-back calls give the minimum interval.
    task automatic do_op(input bit w8, input int a, input int b, input int hold);
        int lat;
        int ed;
        bit eu;
        lat = w8 ? 8 : 2;
        ed  = (a > b) ? a - b : 0;
        eu  = (a < b);
        set_or(w8, hold == 0);
        drive(w8, 1'b1, a, b);
        t_acc = $time;
        chk("in_ready_idle", get_ir(w8), 1);
        @(negedge clk);
        for (int k = 1; k <= lat; k++) begin
            chk("no_early_valid", get_ov(w8), 0);
            if (hold > 0) begin
                drive(w8, 1'b1, 0, 0);
                chk("in_ready_busy", get_ir(w8), 0);
            end else begin
                drive(w8, 1'b0, 0, 0);
            end
            @(negedge clk);
        end
        chk("out_valid", get_ov(w8), 1);
        chk("diff", get_d(w8), ed);
        chk("underflow", get_uf(w8), eu);
        for (int h = 0; h < hold; h++) begin
            drive(w8, 1'b1, 0, 0);
            @(negedge clk);
            chk("hold_valid", get_ov(w8), 1);
            chk("hold_diff", get_d(w8), ed);
            chk("hold_in_ready", get_ir(w8), 0);
        end
        drive(w8, 1'b0, 0, 0);
        set_or(w8, 1'b1);
        @(negedge clk);
        chk("ready_return", get_ir(w8), 1);
        chk("valid_drop", get_ov(w8), 0);
    endtask

    initial begin
        bit saw;
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        or2 = 1'b1;
        or8 = 1'b1;

        // Two reset edges, then release.
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready2", {31'b0, ir2}, 0);
            chk("rst_in_ready8", {31'b0, ir8}, 0);
            chk("rst_out_valid2", {31'b0, ov2}, 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready2", {31'b0, ir2}, 1);
        chk("post_rst_in_ready8", {31'b0, ir8}, 1);
        @(negedge clk);
        chk("post_rst_diff2", {30'b0, d2}, 0);
        chk("post_rst_uf2", {31'b0, uf2}, 0);
        chk("post_rst_out_valid2", {31'b0, ov2}, 0);

        // Directed WIDTH=2 vectors.
        do_op(1'b0, 3, 1, 0);
        do_op(1'b0, 1, 2, 0);
        do_op(1'b0, 2, 2, 0);

        // Exhaustive WIDTH=2, back-to-back, with initiation interval check.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                do_op(1'b0, a, b, 0);
                if (a != 0 || b != 0) chk("interval", 32'(t_acc - t_prev), 40);
                t_prev = t_acc;
            end
        end

        // Backpressure with operand noise while busy, then an unaffected op.
        do_op(1'b0, 3, 0, 5);
        do_op(1'b0, 3, 1, 0);

        // WIDTH=8 vectors.
        do_op(1'b1, 5, 200, 0);
        do_op(1'b1, 200, 5, 0);

        // Reset three cycles into a WIDTH=8 operation aborts it.
        drive(1'b1, 1'b1, 200, 5);
        @(negedge clk);
        drive(1'b1, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready_rst", {31'b0, ir8}, 0);
        @(negedge clk);
        chk("abort_out_valid", {31'b0, ov8}, 0);
        chk("abort_diff", {24'b0, d8}, 0);
        chk("abort_uf", {31'b0, uf8}, 0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) saw = 1'b1;
        end
        chk("abort_no_result", {31'b0, saw}, 0);
        chk("abort_idle", {31'b0, ir8}, 1);
        do_op(1'b1, 9, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sat_sub_serial.md
# sat_sub_serial

Bit-serial saturating subtractor. It is the inverse operation of the team's combinational saturating 2-bit adder. The block accepts two unsigned WIDTH-bit operands over a valid/ready handshake and computes a − b one bit per clock, LSB first. It returns the difference clamped at zero (floor saturation), plus an underflow flag. It serves as the sequential "down" path alongside the adder in the small-ALU datapath, where area matters more than throughput.

## Interface
- WIDTH, default 2: operand and result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- in_valid  input  1  operands a/b present.
- in_ready  output  1  block can accept operands; high only in IDLE and only while rst is low.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff/underflow valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  registered result: a − b if a ≥ b, else 0.
- underflow  output  1  registered; 1 when a < b, i.e. the result was clamped.

## Operation
- FSM states are IDLE, SHIFT and DONE; the reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid & in_ready at an edge: capture a→sa and b→sb, clear borrow, clear count and the working result register; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT: each edge processes bit0 of sa/sb.
  - d = sa[0] ^ sb[0] ^ borrow
  - borrow' = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow)
  - Shift d into the MSB of the working result and shift it right by one. Shift sa and sb right by one. count += 1.
  - On the edge where count reaches WIDTH, go to DONE and load the outputs:
    - diff = final borrow ? 0 : working result (LSB-aligned after WIDTH shifts).
    - underflow = final borrow.
- DONE
  - out_valid=1. diff and underflow are held stable until the handshake completes.
  - On out_valid & out_ready at an edge, go to IDLE.
- in_valid while in SHIFT or DONE is ignored; operands are not sampled and nothing is queued.
- Output hold
  - diff and underflow keep their last loaded value through IDLE and SHIFT.
  - Consumers must qualify them with out_valid.
- Arithmetic
  - Unsigned modulo-2^WIDTH bit arithmetic, then clamped.
  - a == b gives diff=0, underflow=0.
  - b == 0 gives diff=a.
  - The counter is $clog2(WIDTH+1) bits and must not wrap before reaching WIDTH.
- Reset
  - rst high at any edge forces IDLE and clears out_valid, diff, underflow, borrow, count, sa and sb.
  - This applies in every state, including mid-SHIFT or while DONE is stalled. An aborted operation produces no result.
  - in_ready is 0 while rst is high and returns to 1 in the first cycle rst is low.

## Timing
- Acceptance edge E0. Bits are processed on edges E1..E_WIDTH. out_valid rises in the cycle after E_WIDTH, i.e. WIDTH cycles after E0.
- With out_ready held high, the result handshake completes at E_{WIDTH+1}, and in_ready rises in the following cycle. Minimum initiation interval is WIDTH+2 cycles.
- Backpressure: out_valid, diff and underflow are held indefinitely while out_ready=0.
- No combinational path from any input to any output, except in_ready from rst.
- All state updates occur on rising clk only; there is no asynchronous behaviour.

## Test plan
- WIDTH=2, reset for 2 cycles: check in_ready=0 during reset, then 1; out_valid=0, diff=00, underflow=0.
- WIDTH=2, a=11, b=01, out_ready=1: out_valid rises exactly 2 cycles after acceptance with diff=10, underflow=0. Then a=01, b=10 → diff=00, underflow=1. Then a=10, b=10 → diff=00, underflow=0.
- WIDTH=2, exhaustive 16 pairs back-to-back: every diff == max(a−b,0); underflow == (a<b); interval between acceptances is exactly 4 cycles.
- WIDTH=2, a=11, b=00, out_ready=0 for 5 cycles after out_valid: diff=11 and out_valid stay stable all 5 cycles. in_valid pulses with a=00 during SHIFT/DONE are ignored (in_ready=0) and the next result is unaffected.
- WIDTH=8, a=200, b=5 → diff=195, underflow=0 after 8 cycles. a=5, b=200 → diff=0, underflow=1.
- WIDTH=8, rst asserted 3 cycles after acceptance of a=200, b=5: no out_valid ever appears for that operation, diff=0, state is IDLE. A subsequent a=9, b=4 yields diff=5.
